vga_box_compositor: RTL and testbench
=====================================

Name: vga_box_compositor

Overview:
Parametrised successor of the single-player/single-target VGA renderer. Owns the 640x480 timing counters, composites NUM_BOXES square sprites over a background, and emits registered 12-bit VGA colour and syncs. Box positions, sizes, colours and enables are shadow-latched once per frame, so on-screen updates are tear-free. Per-frame overlap flags against box 0 (the player) feed game logic such as target capture.

Parameters:
NUM_BOXES, 4, number of sprite channels; index 0 has highest draw priority.
COORD_W, 10, coordinate and half-size width.
COLOR_W, 12, colour width (4R/4G/4B).
BG_COLOR, 12'h000, background colour.
H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.

Ports:
clk_25mHz  in  1  pixel clock; the only clock.
reset  in  1  asynchronous, active-low reset.
box_x  in  NUM_BOXES*COORD_W  centre x per box, packed with box i at [i*COORD_W +: COORD_W].
box_y  in  NUM_BOXES*COORD_W  centre y per box, same packing.
box_half  in  NUM_BOXES*COORD_W  half-size per box.
box_color  in  NUM_BOXES*COLOR_W  colour per box.
box_en  in  NUM_BOXES  per-box enable.
hSync  out  1  active-low horizontal sync.
vSync  out  1  active-low vertical sync.
VGA_R/VGA_G/VGA_B  out  4 each  colour channels.
x  out  COORD_W  current horizontal counter.
y  out  COORD_W  current vertical counter.
active  out  1  high while the counters are inside the visible area.
screenEnd  out  1  one-cycle pulse on the last cycle of each frame.
hit_mask  out  NUM_BOXES  per-frame overlap of box i with box 0; bit 0 is always 0.
frame_count  out  16  frame counter; wraps.

Behaviour:
- Counters: h in 0..H_TOTAL-1 (H_TOTAL=800); v increments when h wraps; v in 0..V_TOTAL-1 (525).
- active = h<H_ACTIVE && v<V_ACTIVE.
- screenEnd = (h==H_TOTAL-1 && v==V_TOTAL-1).
- Raw hSync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Raw vSync is low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Shadow latch: on the screenEnd cycle, all box_* inputs are copied into shadow registers. Input changes at any other time have no visible effect until the next frame.
- Box extent (shadow values), computed signed at COORD_W+2 bits with no modular wrap:
  - left = cx-half, right = cx+half, top = cy-half, bottom = cy+half.
  - inside = left<=x<=right && top<=y<=bottom, inclusive, so a box is 2*half+1 pixels square.
  - Boxes partially off-screen clip cleanly. cx<half must not wrap to the right edge.
- Priority: lowest-index enabled box covering the pixel wins; otherwise BG_COLOR. When active is low, the colour is 0.
- Latency: colour, hSync and vSync are all registered, so they are exactly 1 cycle behind x/y/active. They stay mutually aligned.
- Hit detection:
  - hit_acc[i] (i>=1) is set on any active pixel inside both box 0 and box i, with both enabled.
  - On screenEnd, hit_mask <= hit_acc, hit_acc <= 0, and frame_count increments.
  - Any pixel that is inside box 0 and box i counts as a hit, including a pixel that box 0 draws over.
- Reset (async assert, sync release by the system):
  - h=v=0; all shadows 0 with box_en shadow 0.
  - hSync=vSync=1, colour 0, hit_mask=0, hit_acc=0, frame_count=0.
  - Mid-frame reset restarts at (0,0). The screen shows BG_COLOR until the first screenEnd after release.
- half=0: the box is a single pixel at its centre.

Decomposition:
- Package vga_pkg holds the timing localparams (H_TOTAL, V_TOTAL, sync start/end), COLOR_W, BG_COLOR default, and a helper function for inclusive signed range compare.
- Sub-module vga_timing_gen contains the h/v counters, active, screenEnd and raw syncs.
- Compositing, shadow registers and hit logic live in the top.

Test Plan:
- Sync timing: run 2 frames after reset. hSync low 96 cycles starting at h=656; vSync low lines 490-491; screenEnd period 420000 cycles.
- Single box: box0 at (100,100), half=5, colour 0F0, enabled. Pixels x,y in 95..105 are 0F0, (94,100) is 000; colour lags x by 1 cycle.
- Priority/clip: box0 at (10,10) half 25, colour 0F0; box1 at (20,20) half 30, colour 00F. (20,20) gives 0F0; (50,50) gives 00F; (634,10) gives 000, with no wrap.
- Tear-free update: change box0 x from 100 to 300 at line 200. The rest of the frame still draws at 100; the next frame draws at 300.
- Hit: boxes 0 and 2 overlap in frame N, box 1 disjoint. After screenEnd of N, hit_mask=4'b0100 and frame_count increments. Move apart, and after the next frame hit_mask=0.
- Reset mid-frame at (320,240): outputs clear immediately; after release x=0,y=0; colour stays 000 until first screenEnd, then latched boxes appear.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour defaults and the signed range helper used by the
// box compositor.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int             COLOR_W  = 12;
    localparam logic [11:0]    BG_COLOR = 12'h000;

    // Width of the signed compare domain; wide enough for any COORD_W+2 extent.
    localparam int CMP_W = 16;

    function automatic logic in_range(input logic signed [CMP_W-1:0] val,
                                      input logic signed [CMP_W-1:0] lo,
                                      input logic signed [CMP_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active window, end-of-frame pulse and
// unregistered (raw) sync levels.
module vga_timing_gen #(
    parameter int COORD_W  = 10,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic [COORD_W-1:0] o_h,
    output logic [COORD_W-1:0] o_v,
    output logic               o_active,
    output logic               o_screen_end,
    output logic               o_hsync_raw,
    output logic               o_vsync_raw
);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    assign o_h          = r_h;
    assign o_v          = r_v;
    assign o_active     = (r_h < H_ACT) && (r_v < V_ACT);
    assign o_screen_end = (r_h == H_LAST) && (r_v == V_LAST);
    assign o_hsync_raw  = !((r_h >= HS_START) && (r_h < HS_END));
    assign o_vsync_raw  = !((r_v >= VS_START) && (r_v < VS_END));

endmodule

// File: rtl/vga_box_compositor.sv
// Composites NUM_BOXES frame-latched square sprites over a background on a VGA raster
// and reports per-frame overlap of every box with box 0.
module vga_box_compositor #(
    parameter int                    NUM_BOXES = 4,
    parameter int                    COORD_W   = 10,
    parameter int                    COLOR_W   = vga_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0]    BG_COLOR  = vga_pkg::BG_COLOR,
    parameter int                    H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int                    H_FP      = vga_pkg::H_FP,
    parameter int                    H_SYNC    = vga_pkg::H_SYNC,
    parameter int                    H_BP      = vga_pkg::H_BP,
    parameter int                    V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int                    V_FP      = vga_pkg::V_FP,
    parameter int                    V_SYNC    = vga_pkg::V_SYNC,
    parameter int                    V_BP      = vga_pkg::V_BP
) (
    input  logic                           clk_25mHz,
    input  logic                           reset,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_x,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_y,
    input  logic [NUM_BOXES*COORD_W-1:0]   box_half,
    input  logic [NUM_BOXES*COLOR_W-1:0]   box_color,
    input  logic [NUM_BOXES-1:0]           box_en,
    output logic                           hSync,
    output logic                           vSync,
    output logic [3:0]                     VGA_R,
    output logic [3:0]                     VGA_G,
    output logic [3:0]                     VGA_B,
    output logic [COORD_W-1:0]             x,
    output logic [COORD_W-1:0]             y,
    output logic                           active,
    output logic                           screenEnd,
    output logic [NUM_BOXES-1:0]           hit_mask,
    output logic [15:0]                    frame_count
);

    import vga_pkg::*;

    logic [COORD_W-1:0] w_h;
    logic [COORD_W-1:0] w_v;
    logic               w_active;
    logic               w_screen_end;
    logic               w_hsync_raw;
    logic               w_vsync_raw;

    vga_timing_gen #(
        .COORD_W (COORD_W),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk        (clk_25mHz),
        .i_rst_n      (reset),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_active     (w_active),
        .o_screen_end (w_screen_end),
        .o_hsync_raw  (w_hsync_raw),
        .o_vsync_raw  (w_vsync_raw)
    );

    // Shadow copies give a tear-free picture: inputs only take effect at frame end.
    logic [NUM_BOXES*COORD_W-1:0] r_sh_x;
    logic [NUM_BOXES*COORD_W-1:0] r_sh_y;
    logic [NUM_BOXES*COORD_W-1:0] r_sh_half;
    logic [NUM_BOXES*COLOR_W-1:0] r_sh_color;
    logic [NUM_BOXES-1:0]         r_sh_en;

    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            r_sh_x     <= '0;
            r_sh_y     <= '0;
            r_sh_half  <= '0;
            r_sh_color <= '0;
            r_sh_en    <= '0;
        end else if (w_screen_end) begin
            r_sh_x     <= box_x;
            r_sh_y     <= box_y;
            r_sh_half  <= box_half;
            r_sh_color <= box_color;
            r_sh_en    <= box_en;
        end
    end

    logic signed [CMP_W-1:0] w_px;
    logic signed [CMP_W-1:0] w_py;
    logic [NUM_BOXES-1:0]    w_inside;

    assign w_px = $signed(CMP_W'(w_h));
    assign w_py = $signed(CMP_W'(w_v));

    // Extents are signed so a box hanging off the left/top edge clips instead of wrapping.
    for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_box
        logic [COORD_W-1:0]      w_cx;
        logic [COORD_W-1:0]      w_cy;
        logic [COORD_W-1:0]      w_hf;
        logic signed [COORD_W+1:0] w_left;
        logic signed [COORD_W+1:0] w_right;
        logic signed [COORD_W+1:0] w_top;
        logic signed [COORD_W+1:0] w_bottom;

        assign w_cx     = r_sh_x[gi*COORD_W +: COORD_W];
        assign w_cy     = r_sh_y[gi*COORD_W +: COORD_W];
        assign w_hf     = r_sh_half[gi*COORD_W +: COORD_W];
        assign w_left   = $signed({2'b00, w_cx}) - $signed({2'b00, w_hf});
        assign w_right  = $signed({2'b00, w_cx}) + $signed({2'b00, w_hf});
        assign w_top    = $signed({2'b00, w_cy}) - $signed({2'b00, w_hf});
        assign w_bottom = $signed({2'b00, w_cy}) + $signed({2'b00, w_hf});

        assign w_inside[gi] = r_sh_en[gi]
                            && in_range(w_px, CMP_W'(w_left), CMP_W'(w_right))
                            && in_range(w_py, CMP_W'(w_top),  CMP_W'(w_bottom));
    end

    logic [COLOR_W-1:0] w_pix;

    always_comb begin
        w_pix = BG_COLOR;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (w_inside[i]) begin
                w_pix = r_sh_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    logic [COLOR_W-1:0] r_color;
    logic               r_hsync;
    logic               r_vsync;

    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            r_color <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_color <= w_active ? w_pix : '0;
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
        end
    end

    // Overlap is judged on coverage, not on the drawn colour, so box 0 occluding box i still hits.
    logic [NUM_BOXES-1:0] w_hit;
    assign w_hit[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_BOXES; gi++) begin : g_hit
        assign w_hit[gi] = w_active && w_inside[0] && w_inside[gi];
    end

    logic [NUM_BOXES-1:0] r_hit_acc;
    logic [NUM_BOXES-1:0] r_hit_mask;
    logic [15:0]          r_frame_count;

    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            r_hit_acc     <= '0;
            r_hit_mask    <= '0;
            r_frame_count <= '0;
        end else if (w_screen_end) begin
            r_hit_mask    <= r_hit_acc;
            r_hit_acc     <= '0;
            r_frame_count <= r_frame_count + 16'd1;
        end else begin
            r_hit_acc     <= r_hit_acc | w_hit;
        end
    end

    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign VGA_R       = r_color[COLOR_W-1 -: 4];
    assign VGA_G       = r_color[COLOR_W-5 -: 4];
    assign VGA_B       = r_color[COLOR_W-9 -: 4];
    assign x           = w_h;
    assign y           = w_v;
    assign active      = w_active;
    assign screenEnd   = w_screen_end;
    assign hit_mask    = r_hit_mask;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor on a shrunken raster (48x40 visible, 60x46 total)
// so that many frames fit in a short run.
module tb_vga_box_compositor;

    localparam int NB = 4;
    localparam int CW = 10;
    localparam int KW = 12;
    localparam int LIMIT = 6000;

    logic              clk_25mHz = 1'b0;
    logic              reset     = 1'b0;
    logic [NB*CW-1:0]  box_x     = '0;
    logic [NB*CW-1:0]  box_y     = '0;
    logic [NB*CW-1:0]  box_half  = '0;
    logic [NB*KW-1:0]  box_color = '0;
    logic [NB-1:0]     box_en    = '0;
    logic              hSync, vSync, active, screenEnd;
    logic [3:0]        VGA_R, VGA_G, VGA_B;
    logic [CW-1:0]     x, y;
    logic [NB-1:0]     hit_mask;
    logic [15:0]       frame_count;

    int checks = 0;
    int errors = 0;
    int exp_fc = 0;
    int cnt;

    wire [11:0] color = {VGA_R, VGA_G, VGA_B};

    always #5 clk_25mHz = ~clk_25mHz;

    vga_box_compositor #(
        .NUM_BOXES(NB), .COORD_W(CW), .COLOR_W(KW), .BG_COLOR(12'h123),
        .H_ACTIVE(48), .H_FP(4), .H_SYNC(6), .H_BP(2),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk_25mHz   (clk_25mHz),
        .reset       (reset),
        .box_x       (box_x),
        .box_y       (box_y),
        .box_half    (box_half),
        .box_color   (box_color),
        .box_en      (box_en),
        .hSync       (hSync),
        .vSync       (vSync),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .x           (x),
        .y           (y),
        .active      (active),
        .screenEnd   (screenEnd),
        .hit_mask    (hit_mask),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25mHz);
        #1;
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $display("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic wait_xy(input int xx, input int yy);
        int n = 0;
        while (!(int'(x) == xx && int'(y) == yy) && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("wait_xy");
    endtask

    // Colour for pixel (px,py) shows one cycle after the counters reach it.
    task automatic pix(input string tag, input int px, input int py, input logic [11:0] expc);
        wait_xy(px, py);
        step();
        check(tag, 32'(color), 32'(expc));
    endtask

    task automatic next_frame();
        int n = 0;
        while (!screenEnd && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) timeout("next_frame");
        step();
        exp_fc++;
    endtask

    task automatic set_box(input int i, input int cx, input int cy, input int h,
                           input logic [11:0] c, input logic en);
        box_x[i*CW +: CW]     = CW'(cx);
        box_y[i*CW +: CW]     = CW'(cy);
        box_half[i*CW +: CW]  = CW'(h);
        box_color[i*KW +: KW] = c;
        box_en[i]             = en;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_hsync", 32'(hSync), 32'd1);
        check("rst_vsync", 32'(vSync), 32'd1);
        check("rst_color", 32'(color), 32'h000);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_hit_mask", 32'(hit_mask), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge clk_25mHz);
        reset = 1'b1;
        #1;

        // Sync timing
        cnt = 0;
        while (hSync && cnt < 200) begin step(); cnt++; end
        check("hsync_fall_x", 32'(x), 32'd53);
        check("hsync_fall_y", 32'(y), 32'd0);
        cnt = 0;
        while (!hSync && cnt < 200) begin step(); cnt++; end
        check("hsync_width", 32'(cnt), 32'd6);
        cnt = 0;
        while (vSync && cnt < LIMIT) begin step(); cnt++; end
        check("vsync_fall_y", 32'(y), 32'd42);
        check("vsync_fall_x", 32'(x), 32'd1);
        cnt = 0;
        while (!vSync && cnt < LIMIT) begin step(); cnt++; end
        check("vsync_width", 32'(cnt), 32'd120);
        cnt = 0;
        while (!screenEnd && cnt < LIMIT) begin step(); cnt++; end
        step();
        cnt = 1;
        while (!screenEnd && cnt < LIMIT) begin step(); cnt++; end
        check("frame_period", 32'(cnt), 32'd2760);
        check("frame_count_1", 32'(frame_count), 32'd1);
        exp_fc = 1;

        // Single box plus a half=0 single-pixel box
        set_box(0, 20, 20, 5, 12'h0F0, 1'b1);
        set_box(1, 40, 30, 0, 12'hF00, 1'b1);
        next_frame();
        check("frame_count_2", 32'(frame_count), 32'(exp_fc));
        pix("box_top_out", 20, 14, 12'h123);
        pix("box_corner_tl", 15, 15, 12'h0F0);
        wait_xy(15, 20);
        check("lag_prev_pixel", 32'(color), 32'h123);
        step();
        check("lag_cur_pixel", 32'(color), 32'h0F0);
        pix("box_right_out", 26, 20, 12'h123);
        pix("box_corner_br", 25, 25, 12'h0F0);
        pix("box_bottom_out", 20, 26, 12'h123);
        pix("half0_left", 39, 30, 12'h123);
        pix("half0_centre", 40, 30, 12'hF00);
        pix("half0_right", 41, 30, 12'h123);
        pix("blank_is_zero", 50, 30, 12'h000);

        // Priority and left/top clipping
        set_box(0, 10, 10, 25, 12'h0F0, 1'b1);
        set_box(1, 20, 20, 18, 12'h00F, 1'b1);
        next_frame();
        check("hit_disjoint", 32'(hit_mask), 32'b0000);
        pix("clip_origin", 0, 0, 12'h0F0);
        pix("no_wrap_bg", 40, 10, 12'h123);
        pix("prio_box0", 20, 20, 12'h0F0);
        pix("prio_box1", 36, 20, 12'h00F);
        pix("box1_only", 37, 37, 12'h00F);

        // Tear-free update mid-frame
        set_box(0, 20, 30, 3, 12'h0F0, 1'b1);
        set_box(1, 0, 0, 0, 12'h000, 1'b0);
        next_frame();
        check("hit_occluded", 32'(hit_mask), 32'b0010);
        wait_xy(0, 20);
        set_box(0, 40, 30, 3, 12'h0F0, 1'b1);
        pix("tear_old_kept", 20, 30, 12'h0F0);
        pix("tear_new_hidden", 40, 30, 12'h123);
        next_frame();
        pix("tear_old_gone", 20, 30, 12'h123);
        pix("tear_new_shown", 40, 30, 12'h0F0);

        // Hit detection: box2 overlaps box0, box1 disjoint, box3 overlaps but disabled
        set_box(0, 20, 20, 4, 12'h0F0, 1'b1);
        set_box(1, 40, 35, 2, 12'hF00, 1'b1);
        set_box(2, 26, 20, 4, 12'h00F, 1'b1);
        set_box(3, 20, 20, 4, 12'hFFF, 1'b0);
        next_frame();
        check("hit_before", 32'(hit_mask), 32'b0000);
        set_box(2, 40, 5, 2, 12'h00F, 1'b1);
        next_frame();
        check("hit_overlap", 32'(hit_mask), 32'b0100);
        check("frame_count_hit", 32'(frame_count), 32'(exp_fc));
        next_frame();
        check("hit_cleared", 32'(hit_mask), 32'b0000);

        // Mid-frame reset
        set_box(0, 20, 20, 3, 12'h0F0, 1'b1);
        set_box(1, 0, 0, 0, 12'h000, 1'b0);
        set_box(2, 0, 0, 0, 12'h000, 1'b0);
        wait_xy(32, 24);
        reset = 1'b0;
        #1;
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        check("mid_rst_color", 32'(color), 32'h000);
        check("mid_rst_hsync", 32'(hSync), 32'd1);
        check("mid_rst_hit_mask", 32'(hit_mask), 32'd0);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge clk_25mHz);
        reset = 1'b1;
        check("release_x", 32'(x), 32'd0);
        check("release_y", 32'(y), 32'd0);
        #1;
        pix("post_rst_bg", 20, 20, 12'h123);
        next_frame();
        check("post_rst_frame_count", 32'(frame_count), 32'd1);
        pix("post_rst_latched", 20, 20, 12'h0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
